input_loader: RTL and testbench
===============================

INPUT_LOADER -- requirements
Module: input_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning the width of the pixel RAM address.
REQ-002 SHALL have parameter NUM_PIXELS, default 784, meaning the number of 1-bit pixels per image.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8, meaning the number of bits per received byte.
REQ-004 SHALL have clk, input, 1, the single clock; all logic acts on its rising edge.
REQ-005 SHALL have rst_n, input, 1, the synchronous active-low reset, sampled on the clk rising edge.
REQ-006 SHALL have start, input, 1, a pulse that restarts loading of a new image at pixel 0.
REQ-007 SHALL have rx_rdy, input, 1, a level that is high while rx_data holds an unconsumed byte.
REQ-008 SHALL have rx_data, input, BYTE_WIDTH, the received byte, with pixel order LSB first.
REQ-009 SHALL have clr_rx_rdy, output, 1, a one-cycle pulse that acknowledges consumption of rx_data.
REQ-010 SHALL have ram_we, output, 1, the write enable of the pixel RAM.
REQ-011 SHALL have ram_addr, output, ADDR_WIDTH, the pixel RAM write address.
REQ-012 SHALL have ram_data, output, 1, the pixel bit to be written.
REQ-013 SHALL have busy, output, 1, high while in the WRITE state.
REQ-014 SHALL have load_done, output, 1, a level that is high in the DONE state.

Function
REQ-015 SHALL implement the states IDLE, WRITE and DONE, and all outputs SHALL be registered.
REQ-016 In IDLE with rx_rdy=1, SHALL capture rx_data into the shift register, clear the bit counter, and move to WRITE.
REQ-017 SHALL assert clr_rx_rdy for exactly the first cycle of WRITE.
REQ-018 If rx_rdy is sampled in cycle N, SHALL drive ram_we=1 in cycles N+1 through N+8, with ram_addr = pixel_cnt+i and ram_data = rx_data[i] for i = 0 to 7.
REQ-019 SHALL increment pixel_cnt once per written bit.
REQ-020 SHALL hold ram_we=0 in IDLE and in DONE; ram_addr and ram_data SHALL hold their last values.
REQ-021 After the bit at address NUM_PIXELS-1 is written, SHALL move to DONE in the next cycle and discard any remaining bits of the byte.
REQ-022 Otherwise, after BYTE_WIDTH bits are written, SHALL return to IDLE; a new byte SHALL be acceptable in the first IDLE cycle.
REQ-023 In DONE, SHALL ignore rx_rdy and SHALL NOT pulse clr_rx_rdy.
REQ-024 start SHALL have priority over rx_rdy in every state: pixel_cnt goes to 0, the state goes to IDLE, load_done goes to 0, and an in-flight byte is abandoned.
REQ-025 When start and rx_rdy are both high in IDLE, SHALL ignore rx_rdy in that cycle, and the byte SHALL be accepted in the following cycle.
REQ-026 pixel_cnt SHALL never exceed NUM_PIXELS-1; no RAM write SHALL occur at address NUM_PIXELS or above.

Reset
REQ-027 When rst_n=0 at a clk edge, SHALL set the state to IDLE, pixel_cnt to 0, and the shift register to 0.
REQ-028 Reset SHALL set ram_we, clr_rx_rdy, busy, load_done, ram_addr and ram_data all to 0.
REQ-029 Reset asserted mid-WRITE SHALL terminate writes in the next cycle; the partial image is not resumed.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, WRITE, DONE) and the NUM_PIXELS and ADDR_WIDTH defaults.
REQ-031 SHALL be a single module with no sub-module; the pixel RAM is instantiated by the parent and driven through ram_we, ram_addr and ram_data.

Verification
REQ-032 Bench SHALL cover a single byte: rx_data=8'hA5 at pixel_cnt=0 -> 8 writes to addresses 0..7 with data 1,0,1,0,0,1,0,1, and clr_rx_rdy pulsed once in cycle N+1.
REQ-033 Bench SHALL cover a full image: 98 bytes -> 784 writes covering addresses 0..783, then load_done=1, and a 99th rx_rdy is left unacknowledged.
REQ-034 Bench SHALL cover a truncated image: NUM_PIXELS=20 with 3 bytes -> writes 0..19 only, bits 4..7 of the third byte are dropped, and DONE is reached.
REQ-035 Bench SHALL cover start mid-byte: start in WRITE cycle 3 of a byte loaded at address 40 -> writes stop after address 42, then the next byte writes addresses 0..7.
REQ-036 Bench SHALL cover reset mid-WRITE: rst_n=0 for one cycle during WRITE -> ram_we=0 the next cycle, all outputs 0, and the next byte lands at address 0.
REQ-037 Bench SHALL cover simultaneous start and rx_rdy in IDLE: rx_data=8'hFF -> no write in that cycle, then writes to addresses 0..7 all 1.

Source files
------------

// File: rtl/input_loader_pkg.sv
// -----------------------------------------------------------------------------
// input_loader_pkg
// Shared definitions for the image input loader: the loader FSM state encoding
// and the default geometry (pixel RAM address width, pixels per image, bits
// per received byte).
// -----------------------------------------------------------------------------
package input_loader_pkg;

    localparam int ADDR_WIDTH_DEF = 10;
    localparam int NUM_PIXELS_DEF = 784;
    localparam int BYTE_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/input_loader.sv
// -----------------------------------------------------------------------------
// input_loader
// Unpacks received bytes into a 1-bit-per-pixel image RAM. Each accepted byte
// is written LSB first, one pixel per clock, at consecutive addresses. Loading
// stops once the last pixel of the image has been written.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   start       in   pulse: restart loading at pixel 0 (wins over rx_rdy)
//   rx_rdy      in   level: rx_data holds an unconsumed byte
//   rx_data     in   received byte, pixel order LSB first
//   clr_rx_rdy  out  one-cycle acknowledge of rx_data consumption
//   ram_we      out  pixel RAM write enable
//   ram_addr    out  pixel RAM write address
//   ram_data    out  pixel bit to write
//   busy        out  high while writing a byte
//   load_done   out  high once the whole image has been written
// -----------------------------------------------------------------------------
module input_loader
    import input_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int BYTE_WIDTH = BYTE_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  rx_rdy,
    input  logic [BYTE_WIDTH-1:0] rx_data,
    output logic                  clr_rx_rdy,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_data,
    output logic                  busy,
    output logic                  load_done
);

    localparam int                    BIT_W     = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);
    localparam logic [BIT_W-1:0]      LAST_BIT  = BIT_W'(BYTE_WIDTH - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pixel_cnt_q, pixel_cnt_d;   // address of the next pixel to write
    logic [BYTE_WIDTH-1:0]   shift_q, shift_d;           // bits of the byte not yet presented
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;       // index of the bit currently on ram_data
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    data_q, data_d;
    logic                    clr_q, clr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Saturating advance: the counter parks on the last pixel so it can never
    // point outside the image.
    function automatic logic [ADDR_WIDTH-1:0] next_pixel(input logic [ADDR_WIDTH-1:0] cnt);
        return (cnt == LAST_ADDR) ? cnt : cnt + 1'b1;
    endfunction

    always_comb begin
        state_d     = state_q;
        pixel_cnt_d = pixel_cnt_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        clr_d       = 1'b0;

        if (start) begin
            state_d     = IDLE;
            pixel_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // The first bit goes out on the same edge that captures the
                    // byte, so the write burst starts in the cycle after rx_rdy.
                    if (rx_rdy) begin
                        state_d     = WRITE;
                        clr_d       = 1'b1;
                        we_d        = 1'b1;
                        addr_d      = pixel_cnt_q;
                        data_d      = rx_data[0];
                        shift_d     = rx_data >> 1;
                        bit_cnt_d   = '0;
                        pixel_cnt_d = next_pixel(pixel_cnt_q);
                    end
                end
                WRITE: begin
                    // ram_we is high for every WRITE cycle, so addr_q is the
                    // address being written right now.
                    if (addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else if (bit_cnt_q == LAST_BIT) begin
                        state_d = IDLE;
                    end else begin
                        we_d        = 1'b1;
                        addr_d      = pixel_cnt_q;
                        data_d      = shift_q[0];
                        shift_d     = shift_q >> 1;
                        bit_cnt_d   = bit_cnt_q + 1'b1;
                        pixel_cnt_d = next_pixel(pixel_cnt_q);
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == WRITE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pixel_cnt_q <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= 1'b0;
            clr_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pixel_cnt_q <= pixel_cnt_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            clr_q       <= clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign clr_rx_rdy = clr_q;
    assign ram_we     = we_q;
    assign ram_addr   = addr_q;
    assign ram_data   = data_q;
    assign busy       = busy_q;
    assign load_done  = done_q;

endmodule

// File: tb/tb_input_loader.sv
// -----------------------------------------------------------------------------
// tb_input_loader
// Two loader instances: u_dut_a with the full 784-pixel image, u_dut_b with a
// 20-pixel image for the truncation case. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled on the falling edge. Writes and
// acknowledge pulses are logged with the cycle number they appeared in.
// -----------------------------------------------------------------------------
module tb_input_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] rx_data;
    logic [1:0] rx_rdy;
    logic [1:0] clr;
    logic [1:0] we;
    logic [1:0] dat;
    logic [1:0] busy;
    logic [1:0] done;
    logic [9:0] addr_a;
    logic [9:0] addr_b;

    always #5 clk = ~clk;

    input_loader #(.ADDR_WIDTH(10), .NUM_PIXELS(784), .BYTE_WIDTH(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_rdy(rx_rdy[0]), .rx_data(rx_data),
        .clr_rx_rdy(clr[0]), .ram_we(we[0]), .ram_addr(addr_a), .ram_data(dat[0]),
        .busy(busy[0]), .load_done(done[0])
    );

    input_loader #(.ADDR_WIDTH(10), .NUM_PIXELS(20), .BYTE_WIDTH(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_rdy(rx_rdy[1]), .rx_data(rx_data),
        .clr_rx_rdy(clr[1]), .ram_we(we[1]), .ram_addr(addr_b), .ram_data(dat[1]),
        .busy(busy[1]), .load_done(done[1])
    );

    // ---------------- monitor ----------------
    typedef struct { int cyc; int addr; int data; } wr_t;
    wr_t wq_a[$];
    wr_t wq_b[$];
    int  cyc = 0;
    int  clr_cnt_a = 0, clr_cyc_a = -1;
    int  clr_cnt_b = 0, clr_cyc_b = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we[0]) wq_a.push_back('{cyc, int'(addr_a), int'(dat[0])});
        if (we[1]) wq_b.push_back('{cyc, int'(addr_b), int'(dat[1])});
        if (clr[0]) begin clr_cnt_a <= clr_cnt_a + 1; clr_cyc_a <= cyc; end
        if (clr[1]) begin clr_cnt_b <= clr_cnt_b + 1; clr_cyc_b <= cyc; end
    end

    function automatic int qsize(input int sel);
        return (sel != 0) ? wq_b.size() : wq_a.size();
    endfunction

    function automatic wr_t qget(input int sel, input int idx);
        return (sel != 0) ? wq_b[idx] : wq_a[idx];
    endfunction

    function automatic int clr_count(input int sel);
        return (sel != 0) ? clr_cnt_b : clr_cnt_a;
    endfunction

    function automatic int clr_cycle(input int sel);
        return (sel != 0) ? clr_cyc_b : clr_cyc_a;
    endfunction

    function automatic int get_addr(input int sel);
        return (sel != 0) ? int'(addr_b) : int'(addr_a);
    endfunction

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic chk_all_zero(input int sel, input string nm);
        chk({nm, "_we"},   int'(we[sel]),   0);
        chk({nm, "_clr"},  int'(clr[sel]),  0);
        chk({nm, "_busy"}, int'(busy[sel]), 0);
        chk({nm, "_done"}, int'(done[sel]), 0);
        chk({nm, "_addr"}, get_addr(sel),   0);
        chk({nm, "_data"}, int'(dat[sel]),  0);
    endtask

    // Presents a byte and holds rx_rdy until the acknowledge is seen.
    // n is the cycle in which rx_rdy is first sampled.
    task automatic send_byte(input int sel, input logic [7:0] b, output int n);
        bit got;
        @(posedge clk); #1;
        rx_data     = b;
        rx_rdy[sel] = 1'b1;
        n           = cyc;
        got         = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (clr[sel]) got = 1'b1;
        end
        chk($sformatf("ack_seen_b%0d", sel), int'(got), 1);
        @(posedge clk); #1;
        rx_rdy[sel] = 1'b0;
    endtask

    // Waits for the loader to leave WRITE, then checks the writes logged since
    // index si: count, cycle, address and bit value, plus the single ack pulse.
    task automatic verify(input int sel, input string nm, input int n, input int si,
                          input int cb, input int base, input logic [7:0] bits,
                          input int nbits);
        bit ok;
        int cnt;
        wr_t w;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (!busy[sel]) ok = 1'b1;
        end
        chk({nm, "_idle"}, int'(ok), 1);
        cnt = qsize(sel) - si;
        chk({nm, "_nwr"}, cnt, nbits);
        for (int i = 0; i < nbits && i < cnt; i++) begin
            w = qget(sel, si + i);
            chk($sformatf("%s_cyc%0d", nm, i),  w.cyc,  n + 1 + i);
            chk($sformatf("%s_addr%0d", nm, i), w.addr, base + i);
            chk($sformatf("%s_data%0d", nm, i), w.data, int'(bits[i]));
        end
        chk({nm, "_nack"},   clr_count(sel) - cb, 1);
        chk({nm, "_ackcyc"}, clr_cycle(sel),      n + 1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] data;
        int         base;
        logic [7:0] bits;   // bits[i] = expected ram_data of write i
    } vec_t;

    vec_t tbl[5];

    initial begin
        int n, si, cb, s;
        logic [7:0] b;

        tbl[0] = '{8'hA5,  0, 8'b1010_0101};
        tbl[1] = '{8'h3C,  8, 8'b0011_1100};
        tbl[2] = '{8'h01, 16, 8'b0000_0001};
        tbl[3] = '{8'h80, 24, 8'b1000_0000};
        tbl[4] = '{8'hFF, 32, 8'b1111_1111};

        rst_n = 1'b0; start = 1'b0; rx_rdy = 2'b00; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero(0, "reset_a");
        chk_all_zero(1, "reset_b");
        @(posedge clk); #1; rst_n = 1'b1;

        // Consecutive bytes from pixel 0.
        for (int i = 0; i < 5; i++) begin
            si = qsize(0); cb = clr_count(0);
            send_byte(0, tbl[i].data, n);
            verify(0, $sformatf("vec%0d", i), n, si, cb, tbl[i].base, tbl[i].bits, 8);
            chk($sformatf("vec%0d_done", i), int'(done[0]), 0);
            $display("vec%0d byte=%h base=%0d checked", i, tbl[i].data, tbl[i].base);
        end

        // start in the third WRITE cycle of a byte at address 40.
        si = qsize(0); cb = clr_count(0);
        @(posedge clk); #1; rx_data = 8'h6B; rx_rdy[0] = 1'b1; n = cyc;
        @(posedge clk); #1; rx_rdy[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("startmid_we",   int'(we[0]),   0);
        chk("startmid_busy", int'(busy[0]), 0);
        repeat (3) @(negedge clk);
        verify(0, "startmid", n, si, cb, 40, 8'b0000_0011, 3);
        si = qsize(0); cb = clr_count(0);
        send_byte(0, 8'hC3, n);
        verify(0, "after_start", n, si, cb, 0, 8'b1100_0011, 8);
        $display("start mid-byte: 3 writes then restart at 0 checked");

        // One-cycle reset during WRITE (pixel_cnt is 8 here).
        si = qsize(0); cb = clr_count(0);
        @(posedge clk); #1; rx_data = 8'h5A; rx_rdy[0] = 1'b1; n = cyc;
        @(posedge clk); #1; rx_rdy[0] = 1'b0;
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero(0, "rstmid");
        verify(0, "rstmid", n, si, cb, 8, 8'b0000_0010, 2);
        si = qsize(0); cb = clr_count(0);
        send_byte(0, 8'h0F, n);
        verify(0, "after_rst", n, si, cb, 0, 8'b0000_1111, 8);
        $display("reset mid-write: writes stop, next byte at 0 checked");

        // start and rx_rdy together in IDLE (pixel_cnt is 8 here).
        si = qsize(0); cb = clr_count(0);
        @(posedge clk); #1; rx_data = 8'hFF; rx_rdy[0] = 1'b1; start = 1'b1; s = cyc;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("simul_no_we", int'(we[0]), 0);
        for (int k = 0; k < 10 && !clr[0]; k++) @(negedge clk);
        @(posedge clk); #1; rx_rdy[0] = 1'b0;
        verify(0, "simul", s + 1, si, cb, 0, 8'b1111_1111, 8);
        $display("start+rx_rdy in IDLE: byte taken next cycle checked");

        // Full image: 98 bytes -> addresses 0..783, then DONE.
        pulse_start();
        for (int j = 0; j < 98; j++) begin
            b = 8'((j * 37 + 11) & 255);
            si = qsize(0); cb = clr_count(0);
            send_byte(0, b, n);
            verify(0, $sformatf("full%0d", j), n, si, cb, j * 8, b, 8);
        end
        chk("full_done", int'(done[0]), 1);
        chk("full_busy", int'(busy[0]), 0);
        si = qsize(0); cb = clr_count(0);
        @(posedge clk); #1; rx_data = 8'h55; rx_rdy[0] = 1'b1;
        repeat (20) @(negedge clk);
        chk("full_extra_nack", clr_count(0) - cb, 0);
        chk("full_extra_nwr",  qsize(0) - si,     0);
        chk("full_extra_done", int'(done[0]),     1);
        @(posedge clk); #1; rx_rdy[0] = 1'b0;
        $display("full image: 784 writes, DONE, 99th byte ignored checked");

        // Truncated 20-pixel image on the second instance.
        pulse_start();
        si = qsize(1); cb = clr_count(1);
        send_byte(1, 8'hFF, n);
        verify(1, "trunc0", n, si, cb, 0, 8'b1111_1111, 8);
        si = qsize(1); cb = clr_count(1);
        send_byte(1, 8'h00, n);
        verify(1, "trunc1", n, si, cb, 8, 8'b0000_0000, 8);
        si = qsize(1); cb = clr_count(1);
        send_byte(1, 8'hAB, n);
        verify(1, "trunc2", n, si, cb, 16, 8'b0000_1011, 4);
        chk("trunc_done", int'(done[1]), 1);
        repeat (5) @(negedge clk);
        chk("trunc_no_more", qsize(1) - si, 4);
        pulse_start();
        @(negedge clk);
        chk("trunc_start_clears_done", int'(done[1]), 0);
        $display("truncated image: writes 0..19 then DONE checked");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the run must always end on its own.
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
